// File: rtl/ser_pkg.sv
// Shared widths and FSM state encoding for the 16-bit serializer.
// Imported by serializer16 and mux16x1.
package ser_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serializer16_mux16x1.sv
// Gate-level 16:1 mux built from a tree of 2:1 AND/OR stages.
// Ports: D (16 data bits), S (4-bit select), Y (selected bit).
module mux16x1
  import ser_pkg::*;
(
  input  logic [WORD_W-1:0] D,
  input  logic [SEL_W-1:0]  S,
  output logic              Y
);

  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;

  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = (D[2*i]   & ~S[0])
                 | (D[2*i+1] &  S[0]);
  end

  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = (l1[2*i]   & ~S[1])
                 | (l1[2*i+1] &  S[1]);
  end

  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = (l2[2*i]   & ~S[2])
                 | (l2[2*i+1] &  S[2]);
  end

  assign Y = (l3[0] & ~S[3]) | (l3[1] & S[3]);

endmodule

// File: rtl/serializer16.sv
// 16-bit parallel-to-serial converter with valid/ready on both sides.
// Ports: clk, rst, load_valid/load_data/load_ready in; ser_* out, sel, done.
module serializer16
  import ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic              ser_out,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_last,
  output logic              done
);

  localparam logic [SEL_W-1:0] HI_IDX = SEL_W'(WORD_W - 1);
  localparam logic [SEL_W-1:0] FIRST_IDX =
    MSB_FIRST ? HI_IDX : '0;
  localparam logic [SEL_W-1:0] LAST_IDX =
    MSB_FIRST ? '0 : HI_IDX;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              done_q, done_d;

  logic bit_acc;
  logic word_acc;
  logic mux_y;

  mux16x1 u_mux (
    .D (word_q),
    .S (sel_q),
    .Y (mux_y)
  );

  always_comb begin
    ser_valid  = (state_q == SHIFT);
    ser_last   = ser_valid && (sel_q == LAST_IDX);
    // Only the last bit frees the word register, so a new word may
    // slip in on that same edge for gapless back-to-back streaming.
    load_ready = (state_q == IDLE) || (ser_last && ser_ready);
    ser_out    = mux_y & ser_valid;
    sel        = sel_q;
    done       = done_q;
    bit_acc    = ser_valid && ser_ready;
    word_acc   = load_valid && load_ready;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    done_d  = bit_acc && ser_last;
    unique case (state_q)
      IDLE: begin
        if (word_acc) begin
          word_d  = load_data;
          sel_d   = FIRST_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_acc) begin
          if (ser_last) begin
            if (word_acc) begin
              word_d = load_data;
              sel_d  = FIRST_IDX;
            end else begin
              state_d = IDLE;
              sel_d   = '0;
            end
          end else if (MSB_FIRST) begin
            sel_d = sel_q - SEL_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serializer16.sv
// Bench for serializer16: LSB-first and MSB-first instances share stimulus.
// A word-level model is checked every cycle, plus literal stream checks.
module tb_serializer16;

  logic        clk;
  logic        rst;
  logic        lv;
  logic        sr;
  logic [15:0] ld;
  logic        lr [2];
  logic        sv [2];
  logic        so [2];
  logic        sl [2];
  logic        dn [2];
  logic [3:0]  sel [2];

  int checks = 0;
  int errors = 0;

  serializer16 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (lr[0]),
    .ser_ready  (sr),
    .ser_valid  (sv[0]),
    .ser_out    (so[0]),
    .sel        (sel[0]),
    .ser_last   (sl[0]),
    .done       (dn[0])
  );

  serializer16 #(.MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv),
    .load_data  (ld),
    .load_ready (lr[1]),
    .ser_ready  (sr),
    .ser_valid  (sv[1]),
    .ser_out    (so[1]),
    .sel        (sel[1]),
    .ser_last   (sl[1]),
    .done       (dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  // Word-level model: busy flag, word, and count of bits already sent.
  bit          mb [2];
  logic [15:0] mw [2];
  int          mc [2];
  bit          md [2];
  bit          mv = 1'b0;

  function automatic int exp_sel(int k);
    if (!mb[k]) return 0;
    return (k == 1) ? 15 - mc[k] : mc[k];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        for (int k = 0; k < 2; k++) begin
          int  es;
          bit  el;
          es = exp_sel(k);
          el = mb[k] && (mc[k] == 15);
          chk($sformatf("m%0d_valid", k), 32'(sv[k]), 32'(mb[k]));
          chk($sformatf("m%0d_sel", k), 32'(sel[k]), 32'(es));
          chk($sformatf("m%0d_out", k), 32'(so[k]),
              32'(mb[k] ? mw[k][es] : 1'b0));
          chk($sformatf("m%0d_last", k), 32'(sl[k]), 32'(el));
          chk($sformatf("m%0d_lready", k), 32'(lr[k]),
              32'(!mb[k] || (el && sr)));
          chk($sformatf("m%0d_done", k), 32'(dn[k]), 32'(md[k]));
        end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        bit el, erdy, nd, wacc;
        el   = mb[k] && (mc[k] == 15);
        erdy = !mb[k] || (el && sr);
        nd   = el && sr;
        wacc = lv && erdy;
        if (rst) begin
          mb[k] = 1'b0;
          mc[k] = 0;
          md[k] = 1'b0;
        end else begin
          if (mb[k] && sr) begin
            if (mc[k] == 15) mb[k] = 1'b0;
            else mc[k] = mc[k] + 1;
          end
          if (wacc) begin
            mb[k] = 1'b1;
            mw[k] = ld;
            mc[k] = 0;
          end
          md[k] = nd;
        end
      end
      if (rst) mv = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [15:0] w);
    lv = 1'b1;
    ld = w;
    step();
    lv = 1'b0;
  endtask

  task automatic wait_done(string n);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn[0] === 1'b1) break;
      step();
    end
    chk(n, 32'(k < 40), 32'd1);
    if (k < 40) step();
  endtask

  logic [15:0] rec0, rec1;
  int nvalid, nones, ndone;

  initial begin
    rst = 1'b1;
    lv  = 1'b0;
    sr  = 1'b0;
    ld  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_lready", 32'(lr[0]), 32'd1);
    chk("rst_valid", 32'(sv[0]), 32'd0);
    chk("rst_out", 32'(so[1]), 32'd0);
    chk("rst_last", 32'(sl[1]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_sel", 32'(sel[1]), 32'd0);
    step();

    // A5C3 streamed with ser_ready high.
    sr = 1'b1;
    load(16'hA5C3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rec0[i] = so[0];
      rec1[i] = so[1];
      chk("lsb_sel_seq", 32'(sel[0]), 32'(i));
      chk("msb_sel_seq", 32'(sel[1]), 32'(15 - i));
      chk("last_pos", 32'(sl[0]), 32'(i == 15));
      step();
    end
    chk("lsb_stream", 32'(rec0), 32'h0000A5C3);
    chk("msb_stream", 32'(rec1), 32'h0000C3A5);
    @(negedge clk);
    chk("done_after", 32'(dn[0]), 32'd1);
    chk("idle_after", 32'(sv[0]), 32'd0);
    step();
    @(negedge clk);
    chk("done_once", 32'(dn[1]), 32'd0);
    step();

    // FFFF then 0000 back to back.
    nvalid = 0;
    nones  = 0;
    ndone  = 0;
    lv = 1'b1;
    ld = 16'hFFFF;
    step();
    ld = 16'h0000;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (i < 32 && sv[0] === 1'b1) nvalid++;
      if (i < 32 && so[0] === 1'b1) nones++;
      if (i < 16 && so[0] !== 1'b1)
        chk("ffff_bit", 32'(so[0]), 32'd1);
      if (dn[0] === 1'b1) ndone++;
      step();
      if (i == 15) lv = 1'b0;
    end
    chk("b2b_valid", 32'(nvalid), 32'd32);
    chk("b2b_ones", 32'(nones), 32'd16);
    chk("b2b_dones", 32'(ndone), 32'd2);

    // Stall three cycles at sel=5.
    load(16'hA5C3);
    repeat (5) step();
    sr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sel", 32'(sel[0]), 32'd5);
      chk("stall_out", 32'(so[0]), 32'd0);
      chk("stall_lready", 32'(lr[0]), 32'd0);
      step();
    end
    sr = 1'b1;
    @(negedge clk);
    chk("resume_sel", 32'(sel[0]), 32'd5);
    step();
    @(negedge clk);
    chk("resume_next", 32'(sel[0]), 32'd6);
    wait_done("stall_done");

    // Reset at sel=9.
    load(16'h5A5A);
    repeat (9) step();
    @(negedge clk);
    chk("pre_rst_sel", 32'(sel[0]), 32'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(sv[0]), 32'd0);
    chk("mid_rst_lready", 32'(lr[0]), 32'd1);
    chk("mid_rst_done", 32'(dn[0]), 32'd0);
    step();
    @(negedge clk);
    chk("mid_rst_done2", 32'(dn[0]), 32'd0);
    load(16'h0001);
    @(negedge clk);
    chk("reload_sel", 32'(sel[0]), 32'd0);
    chk("reload_out", 32'(so[0]), 32'd1);
    wait_done("reload_done");

    // Ignored load at sel=7.
    load(16'h1234);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rec0[i] = so[0];
      if (i == 7) begin
        chk("ign_lready", 32'(lr[0]), 32'd0);
        lv = 1'b1;
        ld = 16'hFFFF;
      end
      step();
      lv = 1'b0;
    end
    chk("ign_stream", 32'(rec0), 32'h00001234);
    @(negedge clk);
    chk("ign_done", 32'(dn[0]), 32'd1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer16.md
SERIALIZER16 -- requirements
Module: serializer16

Interface
REQ-001 Parameter MSB_FIRST, default 0, meaning: 0 = transmit bit 0 first, 1 = transmit bit 15 first.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load_valid  input  1  upstream offers a parallel word.
REQ-005 load_data  input  16  parallel word, sampled only on accept.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 ser_ready  input  1  downstream accepts the current serial bit.
REQ-008 ser_valid  output  1  ser_out carries a valid bit.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 sel  output  4  index of the bit currently on ser_out.
REQ-011 ser_last  output  1  current bit is the final bit of the word.
REQ-012 done  output  1  one-cycle pulse after the final bit is accepted.

Function
REQ-013 States SHALL be IDLE and SHIFT only.
REQ-014 Word accept SHALL be load_valid && load_ready on a rising edge.
REQ-015 Bit accept SHALL be ser_valid && ser_ready on a rising edge.
REQ-016 IDLE: load_ready=1, ser_valid=0; on accept, capture load_data into word_q, load sel with 0 (MSB_FIRST=0) or 15 (MSB_FIRST=1), go to SHIFT.
REQ-017 Latency SHALL be one cycle: first bit valid in the cycle after word accept.
REQ-018 SHIFT: ser_valid=1; ser_out=word_q[sel], combinational from registered word_q and sel.
REQ-019 On bit accept, sel SHALL step +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1); without bit accept, sel, word_q, ser_out SHALL hold.
REQ-020 ser_last SHALL be 1 exactly when sel=15 (MSB_FIRST=0) or sel=0 (MSB_FIRST=1) and state is SHIFT.
REQ-021 In SHIFT, load_ready SHALL equal ser_last && ser_ready; otherwise 0.
REQ-022 Last bit accepted with simultaneous word accept: capture the new word, reload sel, stay in SHIFT; no idle cycle between words.
REQ-023 Last bit accepted without word accept: go to IDLE.
REQ-024 done SHALL pulse high for exactly one cycle, the cycle after every last-bit accept, including back-to-back words.
REQ-025 sel SHALL never wrap inside a word; reaching the end-of-word index always forces reload or IDLE.
REQ-026 In IDLE, ser_out SHALL be 0 and sel SHALL hold its reset value.
REQ-027 A load_valid while load_ready=0 SHALL be ignored, with no capture and no state change.

Reset
REQ-028 While rst=1 at a rising edge, state SHALL become IDLE; word_q=0, sel=0, done=0.
REQ-029 Resulting outputs SHALL be load_ready=1, ser_valid=0, ser_out=0, ser_last=0, done=0.
REQ-030 Reset mid-word SHALL abandon the word, with no done pulse and no further bits.
REQ-031 rst SHALL take priority over simultaneous word or bit accept.

Structure
REQ-032 Package ser_pkg SHALL hold WORD_W=16, SEL_W=4, and the state encodings IDLE=1'b0 and SHIFT=1'b1.
REQ-033 Bit selection SHALL instantiate the team's gate-level mux16x1 (D=word_q, S=sel, Y feeding ser_out gated by ser_valid).
REQ-034 Control logic SHALL be one registered FSM plus the sel counter, with no other sub-modules.

Verification
REQ-035 Bench SHALL cover: reset, then load 16'hA5C3 with ser_ready=1 and MSB_FIRST=0 -> bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles, ser_last on the 16th, done the next cycle.
REQ-036 Bench SHALL cover: same word with MSB_FIRST=1 -> sel counts 15..0 and bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
REQ-037 Bench SHALL cover: 16'hFFFF then 16'h0000 with load_valid held high -> 32 contiguous valid bits (16 ones, 16 zeros), no gap, two done pulses.
REQ-038 Bench SHALL cover: ser_ready low for 3 cycles at sel=5 -> sel, ser_out stable and load_ready=0 throughout; the stream then resumes at sel=5.
REQ-039 Bench SHALL cover: rst asserted at sel=9 -> next cycle IDLE, load_ready=1, ser_valid=0, no done; a subsequent load starts at sel=0.
REQ-040 Bench SHALL cover: load_valid with new data during sel=7 -> ignored, with the original word completing unchanged.
